// File: rtl/int_ctrl_if.sv
// Signal bundle between the interrupt controller, the external lines,
// the pipeline redirect logic and the nesting stack.
interface int_ctrl_if;
  logic [2:0]  irq;
  logic        ie;
  logic        eret;
  logic        ack;
  logic [1:0]  cur_no;
  logic        int_req;
  logic [1:0]  int_no;
  logic [31:0] vec_addr;
  logic        stk_en;
  logic        stk_sel;
  logic [1:0]  stk_no;
  logic [2:0]  pend;

  modport slave (
    input  irq, ie, eret, ack, cur_no,
    output int_req, int_no, vec_addr, stk_en, stk_sel, stk_no, pend
  );

  modport master (
    output irq, ie, eret, ack, cur_no,
    input  int_req, int_no, vec_addr, stk_en, stk_sel, stk_no, pend
  );
endinterface

// File: rtl/int_ctrl.sv
// Interrupt entry/return controller: pending capture, preemption check,
// redirect handshake and push/pop strobes. INT_LEVEL_TRIG_EN selects level-triggered pending.
module int_ctrl #(
  parameter logic [31:0] VEC_BASE   = 32'h0000_0100,
  parameter logic [31:0] VEC_STRIDE = 32'd16,
  parameter int unsigned MAX_DEPTH  = 3
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  int_ctrl_if.slave  bus
);

  localparam logic [1:0] MAX_D = 2'(MAX_DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, PUSH, POP} state_e;

  state_e      state_q, state_d;
  logic [2:0]  pend_q, pend_d;
  logic [1:0]  depth_q, depth_d;
  logic        eret_pend_q, eret_pend_d;
  logic [1:0]  int_no_q, int_no_d;
  logic [31:0] vec_addr_q;
  logic        int_req_q, stk_en_q, stk_sel_q;
  logic [1:0]  stk_no_q;
  logic [1:0]  best_s;
  logic        eret_any_s;

  function automatic logic [1:0] highest(input logic [2:0] p);
    if (p[2])      highest = 2'd3;
    else if (p[1]) highest = 2'd2;
    else if (p[0]) highest = 2'd1;
    else           highest = 2'd0;
  endfunction

  function automatic logic [2:0] num_mask(input logic [1:0] n);
    case (n)
      2'd1:    num_mask = 3'b001;
      2'd2:    num_mask = 3'b010;
      2'd3:    num_mask = 3'b100;
      default: num_mask = 3'b000;
    endcase
  endfunction

  function automatic logic [31:0] vec_of(input logic [1:0] n);
    vec_of = VEC_BASE + (32'(n) * VEC_STRIDE);
  endfunction

  assign best_s     = highest(pend_q);
  assign eret_any_s = eret_pend_q | bus.eret;

  // Next state and entry number; a return always wins over a new entry.
  always_comb begin
    state_d  = state_q;
    int_no_d = int_no_q;
    case (state_q)
      IDLE: begin
        if (eret_any_s) begin
          state_d = POP;
        end else if (bus.ie && (best_s > bus.cur_no) && (depth_q < MAX_D)) begin
          state_d  = REQ;
          int_no_d = best_s;
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        if (bus.ack) state_d = PUSH;
        else         state_d = REQ;
      end
      PUSH: begin
        if (eret_any_s) state_d = POP;
        else            state_d = IDLE;
      end
      POP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Nesting depth, saturating at MAX_DEPTH on push and at zero on pop.
  always_comb begin
    depth_d = depth_q;
    if (state_q == PUSH) begin
      if (depth_q < MAX_D) depth_d = depth_q + 2'd1;
      else                 depth_d = depth_q;
    end else if (state_q == POP) begin
      if (depth_q != 2'd0) depth_d = depth_q - 2'd1;
      else                 depth_d = depth_q;
    end else begin
      depth_d = depth_q;
    end
  end

  // A return seen during the POP cycle itself is kept for the next pop.
  always_comb begin
    eret_pend_d = eret_pend_q;
    if (bus.eret)            eret_pend_d = 1'b1;
    else if (state_q == POP) eret_pend_d = 1'b0;
    else                     eret_pend_d = eret_pend_q;
  end

`ifdef INT_LEVEL_TRIG_EN
  // Level mode: pending simply mirrors the lines one cycle later.
  always_comb begin
    pend_d = bus.irq;
  end
`else
  logic [2:0] irq_q;
  logic [2:0] clr_s;

  // Edge mode: a new rising edge beats the entry clear of the same bit.
  always_comb begin
    clr_s  = 3'b000;
    if (state_q == PUSH) clr_s = num_mask(int_no_q);
    else                 clr_s = 3'b000;
    pend_d = (pend_q & ~clr_s) | (bus.irq & ~irq_q);
  end

  // Previous line levels for edge detection.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) irq_q <= 3'b000;
    else         irq_q <= bus.irq;
  end
`endif

  // Core state and registered outputs, decoded from the next state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      pend_q      <= 3'b000;
      depth_q     <= 2'd0;
      eret_pend_q <= 1'b0;
      int_no_q    <= 2'd0;
      vec_addr_q  <= VEC_BASE;
      int_req_q   <= 1'b0;
      stk_en_q    <= 1'b0;
      stk_sel_q   <= 1'b0;
      stk_no_q    <= 2'd0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      depth_q     <= depth_d;
      eret_pend_q <= eret_pend_d;
      int_no_q    <= int_no_d;
      vec_addr_q  <= vec_of(int_no_d);
      int_req_q   <= (state_d == REQ);
      stk_en_q    <= (state_d == PUSH) || (state_d == POP);
      stk_sel_q   <= (state_d == POP);
      stk_no_q    <= (state_d == PUSH) ? int_no_d : 2'd0;
    end
  end

  assign bus.int_req  = int_req_q;
  assign bus.int_no   = int_no_q;
  assign bus.vec_addr = vec_addr_q;
  assign bus.stk_en   = stk_en_q;
  assign bus.stk_sel  = stk_sel_q;
  assign bus.stk_no   = stk_no_q;
  assign bus.pend     = pend_q;

endmodule

// File: tb/tb_int_ctrl.sv
// Self-checking bench for int_ctrl: event-level reference model plus directed scenarios.
module tb_int_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int_ctrl_if bus();
  int_ctrl dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus));

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Nesting stack model feeding cur_no back, with a manual override.
  logic [1:0] stk [0:3];
  int         sp;
  logic [1:0] stk_top;
  logic       use_stk;
  logic [1:0] man_cur;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) sp <= 0;
    else if (bus.stk_en && !bus.stk_sel && sp < 4) begin
      stk[sp] <= bus.stk_no;
      sp <= sp + 1;
    end else if (bus.stk_en && bus.stk_sel && sp > 0) sp <= sp - 1;
  end
  always_comb begin
    stk_top = 2'd0;
    if (sp > 0) stk_top = stk[sp-1];
  end
  assign bus.cur_no = use_stk ? stk_top : man_cur;

  // Reference model: which event (request, push, pop) the controller shows next cycle.
  logic [2:0] m_pend, m_prev, rise, np;
  bit m_req, m_push, m_pop, m_eret, nreq, npush, npop, ne;
  int m_depth, m_no, nd, nno, b;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pend = 3'b000; m_prev = 3'b000; m_req = 0; m_push = 0; m_pop = 0;
      m_eret = 0; m_depth = 0; m_no = 0;
    end else begin
      b = 0;
      for (int i = 0; i < 3; i++) if (m_pend[i]) b = i + 1;
      rise = bus.irq & ~m_prev;
      m_prev = bus.irq;
      np = m_pend;
      if (m_push) np[m_no-1] = 1'b0;
      np = np | rise;
      ne = m_pop ? bus.eret : (m_eret | bus.eret);
      nd = m_depth;
      if (m_push && nd < 3) nd++;
      if (m_pop && nd > 0) nd--;
      nreq = 0; npush = 0; npop = 0; nno = m_no;
      if (m_req) begin
        if (bus.ack) npush = 1; else nreq = 1;
      end else if (m_push) begin
        if (m_eret || bus.eret) npop = 1;
      end else if (!m_pop) begin
        if (m_eret || bus.eret) npop = 1;
        else if (bus.ie && b > int'(bus.cur_no) && m_depth < 3) begin
          nreq = 1; nno = b;
        end
      end
      m_pend = np; m_eret = ne; m_depth = nd;
      m_req = nreq; m_push = npush; m_pop = npop; m_no = nno;
    end
  end

  // Compare DUT against the model on every falling edge out of reset.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("m_int_req", 32'(bus.int_req), 32'(m_req));
      chk("m_stk_en", 32'(bus.stk_en), 32'(m_push | m_pop));
      chk("m_stk_sel", 32'(bus.stk_sel), 32'(m_pop));
      chk("m_stk_no", 32'(bus.stk_no), m_push ? 32'(m_no) : 32'd0);
      chk("m_pend", 32'(bus.pend), 32'(m_pend));
      if (m_req) begin
        chk("m_int_no", 32'(bus.int_no), 32'(m_no));
        chk("m_vec_addr", bus.vec_addr, 32'h0000_0100 + 32'(m_no) * 32'd16);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    bus.irq = 3'b000; bus.ack = 1'b0; bus.eret = 1'b0;
    rst_n = 1'b0;
    tick(); tick();
    chk("rst_int_req", 32'(bus.int_req), 32'd0);
    chk("rst_int_no", 32'(bus.int_no), 32'd0);
    chk("rst_vec", bus.vec_addr, 32'h0000_0100);
    chk("rst_stk_en", 32'(bus.stk_en), 32'd0);
    chk("rst_pend", 32'(bus.pend), 32'd0);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic wait_req(input int lim);
    int n = 0;
    while (bus.int_req !== 1'b1 && n < lim) begin tick(); n++; end
    chk("req_timeout", 32'(bus.int_req), 32'd1);
  endtask

  task automatic pulse(input logic [2:0] m);
    bus.irq = m; tick(); bus.irq = 3'b000;
  endtask

  task automatic enter(input logic [2:0] m, input logic [1:0] no);
    pulse(m);
    wait_req(10);
    chk("enter_no", 32'(bus.int_no), 32'(no));
    bus.ack = 1'b1; tick(); bus.ack = 1'b0;
    chk("enter_push", {bus.stk_en, bus.stk_sel, bus.stk_no}, {1'b1, 1'b0, no});
    tick();
  endtask

  task automatic ret();
    bus.eret = 1'b1; tick(); bus.eret = 1'b0;
    chk("ret_pop", {bus.stk_en, bus.stk_sel}, 2'b11);
    tick(); tick();
  endtask

  initial begin
    bus.ie = 1'b1; use_stk = 1'b1; man_cur = 2'd0;
    do_reset();

    // Single entry on irq[0] with minimum latency
    bus.irq = 3'b001; tick();
    chk("t1_pend", 32'(bus.pend), 32'b001);
    chk("t1_noreq", 32'(bus.int_req), 32'd0);
    bus.irq = 3'b000; tick();
    chk("t1_req", 32'(bus.int_req), 32'd1);
    chk("t1_no", 32'(bus.int_no), 32'd1);
    chk("t1_vec", bus.vec_addr, 32'h0000_0110);
    bus.ack = 1'b1; tick(); bus.ack = 1'b0;
    chk("t1_push", {bus.stk_en, bus.stk_sel, bus.stk_no}, 4'b1001);
    tick();
    chk("t1_pend_clr", 32'(bus.pend), 32'd0);
    chk("t1_one_strobe", 32'(bus.stk_en), 32'd0);
    ret();

    // Blocked by running level 2, then released by eret
    use_stk = 1'b0; man_cur = 2'd2;
    pulse(3'b001);
    repeat (4) tick();
    chk("t2_noreq", 32'(bus.int_req), 32'd0);
    chk("t2_pend", 32'(bus.pend), 32'b001);
    bus.eret = 1'b1; man_cur = 2'd0; tick(); bus.eret = 1'b0;
    chk("t2_pop", {bus.stk_en, bus.stk_sel}, 2'b11);
    chk("t2_pop_noreq", 32'(bus.int_req), 32'd0);
    wait_req(6);
    chk("t2_no", 32'(bus.int_no), 32'd1);
    do_reset();

    // Simultaneous irq[0] and irq[2]: number 3 first
    use_stk = 1'b1;
    pulse(3'b101);
    wait_req(6);
    chk("t3_no", 32'(bus.int_no), 32'd3);
    chk("t3_vec", bus.vec_addr, 32'h0000_0130);
    bus.ack = 1'b1; tick(); bus.ack = 1'b0; tick();
    chk("t3_pend", 32'(bus.pend), 32'b001);
    repeat (3) tick();
    chk("t3_noreq", 32'(bus.int_req), 32'd0);
    ret();
    wait_req(6);
    chk("t3_no2", 32'(bus.int_no), 32'd1);
    do_reset();

    // Nest 1, 2, 3 then depth limit holds off a further request
    use_stk = 1'b1;
    enter(3'b001, 2'd1);
    enter(3'b010, 2'd2);
    enter(3'b100, 2'd3);
    use_stk = 1'b0; man_cur = 2'd0;
    pulse(3'b001);
    repeat (5) tick();
    chk("t4_depth_block", 32'(bus.int_req), 32'd0);
    chk("t4_pend", 32'(bus.pend), 32'b001);
    bus.eret = 1'b1; tick(); bus.eret = 1'b0;
    chk("t4_pop", {bus.stk_en, bus.stk_sel}, 2'b11);
    wait_req(6);
    chk("t4_no", 32'(bus.int_no), 32'd1);
    do_reset();

    // eret together with the ack: push then pop back-to-back
    use_stk = 1'b1;
    pulse(3'b010);
    wait_req(6);
    bus.ack = 1'b1; bus.eret = 1'b1; tick(); bus.ack = 1'b0; bus.eret = 1'b0;
    chk("t5_push", {bus.stk_en, bus.stk_sel, bus.stk_no}, 4'b1010);
    tick();
    chk("t5_pop", {bus.stk_en, bus.stk_sel, bus.stk_no}, 4'b1100);
    tick();
    chk("t5_idle", 32'(bus.stk_en), 32'd0);
    enter(3'b001, 2'd1);
    enter(3'b010, 2'd2);
    enter(3'b100, 2'd3);
    do_reset();

    // Reset in the middle of a request
    pulse(3'b011);
    wait_req(6);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_req", 32'(bus.int_req), 32'd0);
    chk("t6_pend", 32'(bus.pend), 32'd0);
    chk("t6_stk", 32'(bus.stk_en), 32'd0);
    tick();
    #2 rst_n = 1'b1;
    repeat (4) begin
      tick();
      chk("t6_no_strobe", 32'(bus.stk_en), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/int_ctrl.md
# int_ctrl

Interrupt entry/return controller that drives the nesting stack from the initiating side. It captures requests from three sources and selects the highest-priority pending one. It raises the request only when that interrupt preempts the running level reported by the stack, handshakes the redirect with the pipeline, and issues the push on entry and the pop on return (eret). It sits between the external interrupt lines, the CPU pipeline redirect logic and the interrupt nesting stack.

## Interface
- VEC_BASE, 32'h0000_0100, handler vector for interrupt number 0 (number 0 is never taken; it is the base of the vector arithmetic)
- VEC_STRIDE, 32'd16, byte distance between handler vectors
- MAX_DEPTH, 3, maximum nesting depth accepted; must not exceed the stack capacity
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- irq  in  3  interrupt lines; irq[i-1] is interrupt number i; number 3 is highest priority
- ie  in  1  global interrupt enable
- eret  in  1  one-cycle pulse: the pipeline retired an interrupt return
- ack  in  1  pipeline accepted the redirect to vec_addr
- cur_no  in  2  running interrupt number from the stack top; 0 = none
- int_req  out  1  redirect request to the pipeline
- int_no  out  2  number being entered; valid while int_req=1
- vec_addr  out  32  VEC_BASE + int_no*VEC_STRIDE; valid while int_req=1
- stk_en  out  1  stack strobe
- stk_sel  out  1  0 = push, 1 = pop
- stk_no  out  2  number to push
- pend  out  3  pending register, for debug and CSR read

## Operation
- Pending capture: a rising edge on irq[i] sets pend[i] on that clock edge. pend[i] clears in PUSH for the entered number only. An edge arriving in the same cycle as its clear wins: the bit stays set.
- best = highest set bit number of pend, 0 if pend is empty.
- depth: 2-bit counter. It increments in PUSH and decrements in POP when nonzero. It saturates at MAX_DEPTH and at 0.
- eret_pend: set by an eret pulse in any state. Cleared when POP executes.
- FSM states: IDLE, REQ, PUSH, POP.
- IDLE: if eret_pend or eret, go to POP; eret has priority over a new request. Otherwise, if ie and best>cur_no and depth<MAX_DEPTH, latch int_no=best and go to REQ.
- REQ: int_req=1; int_no and vec_addr are frozen. Neither a change of ie nor a higher arrival withdraws or changes the request. On ack, go to PUSH.
- PUSH: one cycle. stk_en=1, stk_sel=0, stk_no=int_no. Clear pend[int_no]; depth+1. Then go to IDLE.
- POP: one cycle. stk_en=1, stk_sel=1. depth-1 if nonzero; clear eret_pend. Then go to IDLE. A pop at depth 0 still strobes the stack, which ignores it.
- stk_no=0 and stk_sel=0 whenever stk_en=0.
- vec_addr arithmetic is 32-bit, with wrap-around modulo 2^32.

## Timing
- Reset values: state=IDLE, pend=0, depth=0, eret_pend=0, int_req=0, int_no=0, vec_addr=VEC_BASE, stk_en=0, stk_sel=0, stk_no=0.
- Reset asserted mid-operation forces the reset values immediately; it may drop an outstanding request or pop.
- irq edge at clock edge N gives pend set after N. int_req rises after edge N+1 at the earliest, so the minimum latency is 2 cycles.
- ack sampled at edge M gives stk_en=1 for cycle M..M+1 only. cur_no reflects the push from edge M+1, so IDLE at M+1 compares against the updated level.
- eret at edge K (state IDLE) gives the POP strobe in cycle K..K+1. When eret arrives during REQ or PUSH, the POP strobe follows the PUSH cycle.
- ack is held in REQ as long as needed; ack outside REQ is ignored.

## Configuration
- INT_LEVEL_TRIG_EN defined: pend[i] follows irq[i] registered each cycle, so the requests are level-triggered. No clear happens in PUSH; the source must deassert irq inside its handler.
- INT_LEVEL_TRIG_EN undefined: edge capture and clear-on-entry as described above.

## Test plan
- Reset, then a single pulse on irq[0] with ie=1, cur_no=0 -> int_req=1 two cycles later, int_no=1, vec_addr=32'h110. Assert ack -> one push strobe with stk_no=1, and pend=0.
- Running level cur_no=2, pulse irq[0] -> no int_req, pend=3'b001 held. Then eret and cur_no=0 -> pop strobe first, then int_req with int_no=1.
- Pulse irq[0] and irq[2] together in IDLE with cur_no=0 -> int_no=3 is entered first, and pend=3'b001 remains.
- Nest 1, 2, 3 (cur_no fed back from a stack model) -> three pushes, depth=3. A further irq while depth=3 is not requested until eret.
- eret pulse in the same cycle as the REQ->PUSH transition -> push strobe, then pop strobe on the next cycle, ending with depth unchanged.
- Pull rst low while in REQ -> int_req=0 immediately, pend=0, and no strobe after release.
